dp_req_scheduler: RTL and testbench
===================================

Name: dp_req_scheduler

Overview:
- Round-robin scheduler that shares one instance of the registered main/aux datapath (shift stage feeding the ALU stage, registered result and status flags) among N_REQ requesters.
- Accepts one operation at a time over a valid/ready request interface and drives the datapath operand/control inputs.
- Waits the fixed datapath latency, captures final result and status flags, and returns them tagged with the requester index over a valid/ready response interface.

Parameters:
- N_REQ, 4, number of requesters (legal 2..8).
- DP_LATENCY, 1, clock cycles from stable datapath inputs to registered datapath output (legal 1..15).
- ID_W, $clog2(N_REQ), derived localparam: requester index width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_main_data  input  8*N_REQ  main operand; slice i belongs to requester i.
- req_aux_data  input  8*N_REQ  aux operand; slice i belongs to requester i.
- req_control  input  2*N_REQ  datapath control; slice i belongs to requester i.
- dp_main_data  output  8  main operand to datapath.
- dp_aux_data  output  8  aux operand to datapath.
- dp_control  output  2  control to datapath.
- dp_final_result  input  8  registered datapath result.
- dp_status_flags  input  2  registered datapath flags {overflow, nonzero}.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_result  output  8  captured result.
- rsp_flags  output  2  captured flags.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset values: state=IDLE, req_ready=0, dp_main_data=0, dp_aux_data=0, dp_control=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, busy=0, last_grant=N_REQ-1 (requester 0 has top priority first).
- IDLE:
  - Grant g = first i with req_valid[i] set, searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready[g] is asserted combinationally in the same cycle; req_ready is 0 in every other state.
  - On the accept edge T: dp_* registers load slice g, last_grant<=g, rsp_id<=g, cnt<=DP_LATENCY, state->WAIT.
  - If no req_valid bit is set, stay in IDLE.
- WAIT:
  - If cnt!=0, cnt decrements each edge.
  - On the edge where cnt==0 (edge T+DP_LATENCY+1): rsp_result<=dp_final_result, rsp_flags<=dp_status_flags, rsp_valid<=1, state->RESP.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On handshake: rsp_valid<=0, state->IDLE. The next grant comes no earlier than the following cycle.
- dp_* outputs hold the last granted operands in all states; they change only on an accept edge.
- Requesters must hold valid and operands stable until ready. A deasserted req_valid is simply skipped; no grant is lost.
- Accept-to-rsp_valid latency is exactly DP_LATENCY+1 cycles. Maximum throughput is one operation per DP_LATENCY+3 cycles.
- rst in any state (including mid-WAIT or during RESP) drops the in-flight operation, with no response. All registers take their reset values on that edge.
- rst and req_valid asserted together: no accept; rst wins.

Optional Feature:
- Macro: DP_SCHED_STATS_EN.
- Defined: adds output grant_count [16*N_REQ]. Slice i is a saturating count of accepts for requester i; it holds at 0xFFFF and is cleared by rst.
- Undefined: the port and the counters are absent, and all other behaviour is identical.

Test Plan:
- Single op, no contention (DATAPATH = shift/ALU pipeline, N_REQ=4, DP_LATENCY=1):
  - Stimulus: req_valid=4'b0100, main slice2=0x10, aux slice2=0x05, control slice2=2'b00.
  - Required: req_ready=4'b0100 in the accept cycle; dp_main_data=0x10, dp_control=00 next cycle; rsp_valid 2 cycles after accept with rsp_id=2, rsp_result=0x0D, rsp_flags=2'b01.
- Fairness: all four req_valid held high, rsp_ready=1 -> accept order 0,1,2,3,0,1; each accept 4 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_result stay constant; req_ready=0 throughout; after rsp_ready=1, next accept one cycle after the handshake.
- Reset mid-operation: rst pulsed during WAIT -> next cycle rsp_valid=0, busy=0, dp_*=0; with all req_valid high afterwards, requester 0 is granted first.
- Latency parameter: DP_LATENCY=3, control=2'b11, aux=0x3C -> rsp_valid exactly 4 cycles after accept, rsp_result=0x3C, rsp_flags=2'b0x with flag[0] equal to |main.
- Stats (DP_SCHED_STATS_EN defined): 3 accepts for requester 1 -> grant_count slice1=3, others 0; counter preloaded to 0xFFFF by force, one more accept -> stays at 0xFFFF.

Source files
------------

// File: rtl/dp_req_scheduler.sv
// Round-robin scheduler sharing one registered shift/ALU datapath among N_REQ requesters.
// Optional per-requester saturating accept counters when DP_SCHED_STATS_EN is defined.
module dp_req_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DP_LATENCY = 1,
    localparam int unsigned ID_W      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_main_data,
    input  logic [8*N_REQ-1:0]   req_aux_data,
    input  logic [2*N_REQ-1:0]   req_control,
    output logic [7:0]           dp_main_data,
    output logic [7:0]           dp_aux_data,
    output logic [1:0]           dp_control,
    input  logic [7:0]           dp_final_result,
    input  logic [1:0]           dp_status_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic [1:0]           rsp_flags,
    output logic                 busy
`ifdef DP_SCHED_STATS_EN
    ,
    output logic [16*N_REQ-1:0]  grant_count
`endif
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [7:0]       dp_main_q, dp_main_d;
    logic [7:0]       dp_aux_q, dp_aux_d;
    logic [1:0]       dp_ctrl_q, dp_ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [1:0]       rsp_flags_q, rsp_flags_d;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             accept;

    // Search starts just past the last winner and wraps, giving round-robin fairness.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_grant_q) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept    = (state_q == StIdle) && grant_found;
    assign req_ready = (accept && !rst) ? (N_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        dp_main_d    = dp_main_q;
        dp_aux_d     = dp_aux_q;
        dp_ctrl_d    = dp_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    dp_main_d    = req_main_data[grant_idx*8 +: 8];
                    dp_aux_d     = req_aux_data[grant_idx*8 +: 8];
                    dp_ctrl_d    = req_control[grant_idx*2 +: 2];
                    last_grant_d = grant_idx;
                    rsp_id_d     = grant_idx;
                    cnt_d        = CNT_W'(DP_LATENCY);
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_result_d = dp_final_result;
                    rsp_flags_d  = dp_status_flags;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            dp_main_q    <= '0;
            dp_aux_q     <= '0;
            dp_ctrl_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            dp_main_q    <= dp_main_d;
            dp_aux_q     <= dp_aux_d;
            dp_ctrl_q    <= dp_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign dp_main_data = dp_main_q;
    assign dp_aux_data  = dp_aux_q;
    assign dp_control   = dp_ctrl_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flags    = rsp_flags_q;
    assign busy         = (state_q != StIdle);

`ifdef DP_SCHED_STATS_EN
    logic [N_REQ-1:0][15:0] grant_count_q, grant_count_d;

    always_comb begin
        grant_count_d = grant_count_q;
        if (accept && (grant_count_q[grant_idx] != 16'hFFFF)) begin
            grant_count_d[grant_idx] = grant_count_q[grant_idx] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_dp_req_scheduler.sv
// Directed bench for dp_req_scheduler with a behavioural shift/ALU datapath model.
// Stats checks run only when DP_SCHED_STATS_EN is defined.
module tb_dp_req_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_valid3;
    logic [3:0]  req_ready, req_ready3;
    logic [31:0] req_main_data, req_aux_data;
    logic [7:0]  req_control;
    logic [7:0]  dp_main_data, dp_aux_data, dp_main_data3, dp_aux_data3;
    logic [1:0]  dp_control, dp_control3;
    logic        rsp_valid, rsp_ready, rsp_valid3, rsp_ready3;
    logic [1:0]  rsp_id, rsp_id3;
    logic [7:0]  rsp_result, rsp_result3;
    logic [1:0]  rsp_flags, rsp_flags3;
    logic        busy, busy3;
    logic [9:0]  pipe1;
    logic [9:0]  pipe3 [3];
`ifdef DP_SCHED_STATS_EN
    logic [63:0] grant_count, grant_count3;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Datapath model: shift stage then ALU; returns {overflow, nonzero, result}.
    function automatic logic [9:0] dp_f(input logic [7:0] m, input logic [7:0] a,
                                        input logic [1:0] c);
        logic [8:0] s;
        logic [7:0] sh;
        logic [7:0] r;
        logic       ov;
        logic       nz;
        ov = 1'b0;
        case (c)
            2'b00: begin sh = m >> 1; s = {1'b0, sh} + {1'b0, a}; r = s[7:0]; ov = s[8]; end
            2'b01: begin sh = m << 1; s = {1'b0, sh} - {1'b0, a}; r = s[7:0]; ov = s[8]; end
            2'b10: r = m ^ a;
            default: r = a;
        endcase
        nz = (c == 2'b11) ? |m : |r;
        return {ov, nz, r};
    endfunction

    always @(posedge clk) begin
        pipe1    <= dp_f(dp_main_data, dp_aux_data, dp_control);
        pipe3[0] <= dp_f(dp_main_data3, dp_aux_data3, dp_control3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    dp_req_scheduler #(.N_REQ(4), .DP_LATENCY(1)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_main_data   (req_main_data),
        .req_aux_data    (req_aux_data),
        .req_control     (req_control),
        .dp_main_data    (dp_main_data),
        .dp_aux_data     (dp_aux_data),
        .dp_control      (dp_control),
        .dp_final_result (pipe1[7:0]),
        .dp_status_flags (pipe1[9:8]),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_result      (rsp_result),
        .rsp_flags       (rsp_flags),
        .busy            (busy)
`ifdef DP_SCHED_STATS_EN
        ,
        .grant_count     (grant_count)
`endif
    );

    dp_req_scheduler #(.N_REQ(4), .DP_LATENCY(3)) u_dut3 (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid3),
        .req_ready       (req_ready3),
        .req_main_data   (req_main_data),
        .req_aux_data    (req_aux_data),
        .req_control     (req_control),
        .dp_main_data    (dp_main_data3),
        .dp_aux_data     (dp_aux_data3),
        .dp_control      (dp_control3),
        .dp_final_result (pipe3[2][7:0]),
        .dp_status_flags (pipe3[2][9:8]),
        .rsp_valid       (rsp_valid3),
        .rsp_ready       (rsp_ready3),
        .rsp_id          (rsp_id3),
        .rsp_result      (rsp_result3),
        .rsp_flags       (rsp_flags3),
        .busy            (busy3)
`ifdef DP_SCHED_STATS_EN
        ,
        .grant_count     (grant_count3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] m, input logic [7:0] a,
                          input logic [1:0] c);
        req_main_data[i*8 +: 8] = m;
        req_aux_data[i*8 +: 8]  = a;
        req_control[i*2 +: 2]   = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int acc_id [6];
    int acc_cyc [6];
    int n_acc;

    initial begin
        rst           = 1'b1;
        req_valid     = '0;
        req_valid3    = '0;
        rsp_ready     = 1'b1;
        rsp_ready3    = 1'b1;
        req_main_data = '0;
        req_aux_data  = '0;
        req_control   = '0;
        tick();
        tick();

        // Reset state, and rst beating a simultaneous request.
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dp_main", 64'(dp_main_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        tick();
        check("rst_no_accept_busy", 64'(busy), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single op, no contention.
        set_op(2, 8'h10, 8'h05, 2'b00);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check("single_dp_main", 64'(dp_main_data), 64'h10);
        check("single_dp_ctrl", 64'(dp_control), 64'd0);
        check("single_busy", 64'(busy), 64'd1);
        check("single_ready_wait", 64'(req_ready), 64'd0);
        tick();
        check("single_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_id", 64'(rsp_id), 64'd2);
        check("single_rsp_result", 64'(rsp_result), 64'h0D);
        check("single_rsp_flags", 64'(rsp_flags), 64'b01);
        tick();
        check("single_rsp_done", 64'(rsp_valid), 64'd0);
        check("single_idle", 64'(busy), 64'd0);

        // Fairness from reset with everyone requesting.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 8'(8'h20 + i), 8'h01, 2'b10);
        req_valid = 4'hF;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 6; c++) begin
            #1;
            if (req_ready != '0) begin
                acc_id[n_acc]  = $clog2(req_ready);
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            tick();
        end
        check("fair_count", 64'(n_acc), 64'd6);
        check("fair_order0", 64'(acc_id[0]), 64'd0);
        check("fair_order1", 64'(acc_id[1]), 64'd1);
        check("fair_order2", 64'(acc_id[2]), 64'd2);
        check("fair_order3", 64'(acc_id[3]), 64'd3);
        check("fair_order4", 64'(acc_id[4]), 64'd0);
        check("fair_order5", 64'(acc_id[5]), 64'd1);
        for (int k = 1; k < 6; k++) check("fair_gap", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd4);
        req_valid = '0;

        // Backpressure: response held, no grants until handshake.
        do_reset();
        rsp_ready = 1'b0;
        set_op(3, 8'h81, 8'h90, 2'b01);
        req_valid = 4'b1000;
        #1;
        check("bp_ready", 64'(req_ready), 64'b1000);
        tick();
        set_op(0, 8'h10, 8'h05, 2'b00);
        req_valid = 4'b0001;
        tick();
        tick();
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_rsp_id", 64'(rsp_id), 64'd3);
        check("bp_rsp_result", 64'(rsp_result), 64'h72);
        check("bp_rsp_flags", 64'(rsp_flags), 64'b11);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_id", 64'(rsp_id), 64'd3);
            check("bp_hold_result", 64'(rsp_result), 64'h72);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_ready", 64'(req_ready), 64'd0);
        tick();
        check("bp_after_hs_valid", 64'(rsp_valid), 64'd0);
        check("bp_after_hs_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        check("bp_next_dp_main", 64'(dp_main_data), 64'h10);
        tick();
        tick();
        check("bp_next_rsp_id", 64'(rsp_id), 64'd0);
        check("bp_next_rsp_result", 64'(rsp_result), 64'h0D);
        tick();

        // Reset mid-operation drops the response.
        do_reset();
        set_op(1, 8'h22, 8'h33, 2'b10);
        req_valid = 4'b0010;
        #1;
        check("midrst_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        check("midrst_busy_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_dp", 64'({dp_main_data, dp_aux_data, dp_control}), 64'd0);
        req_valid = 4'hF;
        #1;
        check("midrst_first_grant", 64'(req_ready), 64'b0001);
        req_valid = '0;
        tick();
        tick();
        check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        // DP_LATENCY=3 instance.
        set_op(0, 8'h5A, 8'h3C, 2'b11);
        req_valid3 = 4'b0001;
        #1;
        check("lat3_ready", 64'(req_ready3), 64'b0001);
        tick();
        req_valid3 = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("lat3_early", 64'(rsp_valid3), 64'd0);
        end
        tick();
        check("lat3_rsp_valid", 64'(rsp_valid3), 64'd1);
        check("lat3_rsp_result", 64'(rsp_result3), 64'h3C);
        check("lat3_rsp_flags", 64'(rsp_flags3), 64'b01);
        tick();
        set_op(1, 8'h00, 8'h3C, 2'b11);
        req_valid3 = 4'b0010;
        tick();
        req_valid3 = '0;
        repeat (4) tick();
        check("lat3_zero_valid", 64'(rsp_valid3), 64'd1);
        check("lat3_zero_id", 64'(rsp_id3), 64'd1);
        check("lat3_zero_flags", 64'(rsp_flags3), 64'b00);
        tick();

`ifdef DP_SCHED_STATS_EN
        do_reset();
        set_op(1, 8'h01, 8'h02, 2'b00);
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0010;
            #1;
            check("stats_ready", 64'(req_ready), 64'b0010);
            tick();
            req_valid = '0;
            repeat (3) tick();
        end
        check("stats_count3", grant_count, {16'd0, 16'd0, 16'd3, 16'd0});
        force u_dut.grant_count_q = {16'd0, 16'd0, 16'hFFFF, 16'd0};
        #1;
        release u_dut.grant_count_q;
        req_valid = 4'b0010;
        #1;
        check("stats_sat_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        check("stats_sat", grant_count, {16'd0, 16'd0, 16'hFFFF, 16'd0});
        repeat (3) tick();
        do_reset();
        check("stats_rst", grant_count, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
